// File: rtl/cdc_hsk_pkg.sv
// Shared types and helpers for the cdc_handshake source-side controller.
package cdc_hsk_pkg;

    typedef enum logic [1:0] {
        HSK_IDLE,
        HSK_SEND,
        HSK_RELEASE
    } hsk_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hsk_src_fifo.sv
// Small register-based FIFO buffering producer words ahead of the handshake FSM.
module hsk_src_fifo
    import cdc_hsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic                                 pop,
    output logic [DATA_WIDTH-1:0]                head,
    output logic                                 full,
    output logic                                 empty,
    output logic [level_width(FIFO_DEPTH)-1:0]   level
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = level_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [LevelW-1:0]     level_q;
    logic                  push_en;
    logic                  pop_en;

    assign full    = (level_q == LevelW'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Payload storage needs no reset; validity is tracked by level_q.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_en, pop_en})
                2'b10:   level_q <= level_q + LevelW'(1);
                2'b01:   level_q <= level_q - LevelW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/cdc_hsk_src_ctrl.sv
// Source-domain driver for cdc_handshake: FIFO-buffered 4-phase send/rcv sequencer.
// Optional handshake timeout flag enabled by defining CDC_HSK_SRC_TIMEOUT_EN.
module cdc_hsk_src_ctrl
    import cdc_hsk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [DATA_WIDTH-1:0]                in_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic [DATA_WIDTH-1:0]                hsk_data_o,
    output logic                                 hsk_send_o,
    input  logic                                 hsk_rcv_i,
    output logic [level_width(FIFO_DEPTH)-1:0]   level_o,
    output logic                                 busy_o,
    output logic                                 err_timeout_o
);

    hsk_state_e            state_q, state_d;
    logic                  send_q, send_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                                fifo_pop;
    logic [DATA_WIDTH-1:0]               fifo_head;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [level_width(FIFO_DEPTH)-1:0]  fifo_level;

    hsk_src_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (in_valid_i),
        .wdata  (in_data_i),
        .pop    (fifo_pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // A stale rcv (e.g. left over across a reset) must fall before a new send starts.
    always_comb begin
        state_d  = state_q;
        send_d   = send_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            HSK_IDLE: begin
                if (!fifo_empty && !hsk_rcv_i) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head;
                    send_d   = 1'b1;
                    state_d  = HSK_SEND;
                end
            end
            HSK_SEND: begin
                if (hsk_rcv_i) begin
                    send_d  = 1'b0;
                    state_d = HSK_RELEASE;
                end
            end
            HSK_RELEASE: begin
                if (!hsk_rcv_i) begin
                    state_d = HSK_IDLE;
                end
            end
            default: begin
                send_d  = 1'b0;
                state_d = HSK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HSK_IDLE;
            send_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o = !fifo_full;
    assign hsk_data_o = data_q;
    assign hsk_send_o = send_q;
    assign level_o    = fifo_level;
    assign busy_o     = (state_q != HSK_IDLE) || (fifo_level != '0);

`ifdef CDC_HSK_SRC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_q, err_d;

    // Counter saturates so a very long SEND cannot wrap; the flag is sticky anyway.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        if (state_q == HSK_IDLE && state_d == HSK_SEND) begin
            tmo_cnt_d = '0;
        end else if (state_q == HSK_SEND) begin
            if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                err_d = 1'b1;
            end
            if (tmo_cnt_q != CntW'(TIMEOUT_CYCLES)) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign err_timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hsk_src_ctrl.sv
// Self-checking bench for cdc_hsk_src_ctrl: vector table, hand sequences and a randomized scoreboard.
module tb_cdc_hsk_src_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
`ifdef CDC_HSK_SRC_TIMEOUT_EN
    localparam logic TMO_EXP = 1'b1;
`else
    localparam logic TMO_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] hsk_data;
    logic          hsk_send;
    logic          rcv;
    logic [2:0]    level;
    logic          busy;
    logic          err_tmo;

    cdc_hsk_src_ctrl #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .hsk_data_o    (hsk_data),
        .hsk_send_o    (hsk_send),
        .hsk_rcv_i     (rcv),
        .level_o       (level),
        .busy_o        (busy),
        .err_timeout_o (err_tmo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          rcv;
        logic          exp_send;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_level;
        logic          exp_ready;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                                input logic es, input logic [DW-1:0] ed,
                                input logic [2:0] el, input logic er);
        vec_t t;
        t.valid = v; t.data = d; t.rcv = r;
        t.exp_send = es; t.exp_data = ed; t.exp_level = el; t.exp_ready = er;
        return t;
    endfunction

    // Scoreboard state: words accepted but not yet launched, and launched words in order.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sent_q[$];
    logic          prev_send;
    logic          prev_rcv;
    logic [DW-1:0] cur_word;
    int            wait_cnt;
    int            next_val;
    int            rises;
    logic [DW-1:0] base;

    task automatic do_reset(input logic rcv_val);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rcv      = rcv_val;
        @(negedge clk);
        check("rst_send", 32'(hsk_send), 32'(0));
        check("rst_data", 32'(hsk_data), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_err", 32'(err_tmo), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_model(input logic [DW-1:0] b, input int dly);
        model_q.delete();
        sent_q.delete();
        prev_send = 1'b0;
        prev_rcv  = rcv;
        rises     = 0;
        next_val  = 0;
        base      = b;
        wait_cnt  = dly;
    endtask

    // One clock of automatic stimulus: observe, respond on rcv, offer a new word.
    task automatic auto_cycle(input int lo, input int hi, input int push_pct,
                              input bit counting, input int max_words);
        logic [DW-1:0] exp;
        if (hsk_send && !prev_send) begin
            rises++;
            check("send_needs_rcv_low", 32'(prev_rcv), 32'(0));
            if (model_q.size() == 0) begin
                check("unexpected_send", 32'(1), 32'(0));
            end else begin
                exp = model_q.pop_front();
                check("fifo_order", 32'(hsk_data), 32'(exp));
            end
            sent_q.push_back(hsk_data);
            cur_word = hsk_data;
        end else if (hsk_send) begin
            check("data_stable", 32'(hsk_data), 32'(cur_word));
        end
        if (prev_send && !hsk_send) begin
            check("drop_needs_rcv", 32'(prev_rcv), 32'(1));
        end
        check("level", 32'(level), 32'(model_q.size()));
        check("ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
        prev_send = hsk_send;
        if (hsk_send != rcv) begin
            if (wait_cnt <= 0) begin
                rcv      = hsk_send;
                wait_cnt = $urandom_range(hi, lo);
            end else begin
                wait_cnt--;
            end
        end
        prev_rcv = rcv;
        in_valid = 1'b0;
        if ((!counting || next_val < max_words) && $urandom_range(99) < push_pct) begin
            in_valid = 1'b1;
            in_data  = counting ? base + DW'(next_val) : DW'($urandom);
        end
        if (in_valid && in_ready) begin
            model_q.push_back(in_data);
            if (counting) next_val++;
        end
        @(negedge clk);
    endtask

    vec_t vecs[16];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rcv      = 1'b0;

        // Table: rcv high out of reset blocks sending; then fill until full with rcv held low.
        vecs[0]  = mk(1, 16'h1111, 1, 0, 16'h0000, 3'd1, 1);
        vecs[1]  = mk(1, 16'h2222, 1, 0, 16'h0000, 3'd2, 1);
        vecs[2]  = mk(0, 16'h0000, 1, 0, 16'h0000, 3'd2, 1);
        vecs[3]  = mk(0, 16'h0000, 0, 1, 16'h1111, 3'd1, 1);
        vecs[4]  = mk(1, 16'h3333, 0, 1, 16'h1111, 3'd2, 1);
        vecs[5]  = mk(1, 16'h4444, 0, 1, 16'h1111, 3'd3, 1);
        vecs[6]  = mk(1, 16'h5555, 0, 1, 16'h1111, 3'd4, 0);
        vecs[7]  = mk(1, 16'h6666, 0, 1, 16'h1111, 3'd4, 0);
        vecs[8]  = mk(1, 16'h6666, 0, 1, 16'h1111, 3'd4, 0);
        vecs[9]  = mk(0, 16'h0000, 1, 0, 16'h1111, 3'd4, 0);
        vecs[10] = mk(0, 16'h0000, 1, 0, 16'h1111, 3'd4, 0);
        vecs[11] = mk(0, 16'h0000, 0, 0, 16'h1111, 3'd4, 0);
        vecs[12] = mk(0, 16'h0000, 0, 1, 16'h2222, 3'd3, 1);
        vecs[13] = mk(1, 16'h7777, 1, 0, 16'h2222, 3'd4, 0);
        vecs[14] = mk(0, 16'h0000, 0, 0, 16'h2222, 3'd4, 0);
        vecs[15] = mk(0, 16'h0000, 0, 1, 16'h3333, 3'd3, 1);

        do_reset(1'b1);
        check("ready_after_rst", 32'(in_ready), 32'(1));
        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            rcv      = vecs[i].rcv;
            @(negedge clk);
            check($sformatf("vec%0d_send", i), 32'(hsk_send), 32'(vecs[i].exp_send));
            check($sformatf("vec%0d_data", i), 32'(hsk_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
        end

        // Single word with a fixed 6-cycle responder.
        do_reset(1'b0);
        clear_model(16'hA5A5, 6);
        for (int c = 0; c < 40; c++) auto_cycle(6, 6, 100, 1'b1, 1);
        check("single_rises", 32'(rises), 32'(1));
        check("single_word", 32'(sent_q.size() > 0 ? sent_q[0] : 16'h0), 32'(16'hA5A5));
        check("single_busy", 32'(busy), 32'(0));
        check("single_send", 32'(hsk_send), 32'(0));

        // Burst 0..7 with random responder delays 2..9.
        do_reset(1'b0);
        clear_model(16'h0000, 3);
        for (int c = 0; c < 400 && !(sent_q.size() == 8 && !rcv && !hsk_send && !busy); c++) begin
            auto_cycle(2, 9, 100, 1'b1, 8);
        end
        check("burst_count", 32'(sent_q.size()), 32'(8));
        for (int i = 0; i < 8 && i < sent_q.size(); i++) begin
            check($sformatf("burst_word%0d", i), 32'(sent_q[i]), 32'(i));
        end
        check("burst_busy", 32'(busy), 32'(0));

        // Random traffic and responder timing, then drain.
        do_reset(1'b0);
        clear_model(16'h0000, 1);
        for (int c = 0; c < 600; c++) auto_cycle(1, 5, 60, 1'b0, 0);
        for (int c = 0; c < 300 && (busy || rcv || model_q.size() != 0); c++) begin
            auto_cycle(1, 5, 0, 1'b0, 0);
        end
        check("rand_drained", 32'(model_q.size()), 32'(0));
        check("rand_busy", 32'(busy), 32'(0));
        check("rand_err", 32'(err_tmo), 32'(0));

        // Reset during SEND with three words queued, stale rcv held across release.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hC000 + DW'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_send", 32'(hsk_send), 32'(1));
        check("mid_level", 32'(level), 32'(3));
        check("mid_data", 32'(hsk_data), 32'(16'hC000));
        #2 rst_n = 1'b0;
        #1;
        check("async_send_drop", 32'(hsk_send), 32'(0));
        check("async_flush", 32'(level), 32'(0));
        @(negedge clk);
        rcv   = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stale_rcv_send", 32'(hsk_send), 32'(0));
            check("stale_rcv_level", 32'(level), 32'(0));
            check("stale_rcv_ready", 32'(in_ready), 32'(1));
        end
        rcv = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("post_rst_no_send", 32'(hsk_send), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));
        in_valid = 1'b1;
        in_data  = 16'hD000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_new_send", 32'(hsk_send), 32'(1));
        check("post_rst_new_data", 32'(hsk_data), 32'(16'hD000));

        // Timeout: rcv held low for TMO SEND cycles.
        do_reset(1'b0);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !hsk_send; c++) @(negedge clk);
        check("tmo_send_start", 32'(hsk_send), 32'(1));
        for (int c = 0; c < int'(TMO) - 1; c++) @(negedge clk);
        check("tmo_not_yet", 32'(err_tmo), 32'(0));
        @(negedge clk);
        check("tmo_fire", 32'(err_tmo), 32'(TMO_EXP));
        check("tmo_no_abort", 32'(hsk_send), 32'(1));
        rcv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rcv = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("tmo_done_send", 32'(hsk_send), 32'(0));
        check("tmo_sticky", 32'(err_tmo), 32'(TMO_EXP));
        check("tmo_busy", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
